vector_d_sram_req_arbiter: RTL
==============================

Name: vector_d_sram_req_arbiter

Overview:
- Upstream stage of the lane's vector data SRAM wrapper.
- Arbitrates NumReq requesters (operand requesters, load/store unit, slide unit) onto one SRAM port using round-robin arbitration.
- Registers the winning request toward the SRAM.
- Tracks each issued read through a Latency-deep pipeline and routes the returned data to the originating requester with a one-hot valid.

Parameters:
NumReq, 4, number of requesters (>=2)
NumWords, 1024, SRAM depth
DataWidth, 128, SRAM word width
ByteWidth, 8, byte width for byte enables
Latency, 1, SRAM read latency in cycles (>=1), same value as the SRAM instance
AddrWidth, $clog2(NumWords), derived, do not override
BeWidth, ceil(DataWidth/ByteWidth), derived, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester grant (one-hot or zero)
req_we_i  in  NumReq  write enable per requester
req_addr_i  in  NumReq*AddrWidth  word address per requester
req_wdata_i  in  NumReq*DataWidth  write data per requester
req_be_i  in  NumReq*BeWidth  byte enables per requester
resp_valid_o  out  NumReq  one-hot read-data valid
resp_rdata_o  out  DataWidth  read data, shared by all requesters
sram_req_o  out  1  SRAM request
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  AddrWidth  SRAM address
sram_wdata_o  out  DataWidth  SRAM write data
sram_be_o  out  BeWidth  SRAM byte enables
sram_rdata_i  in  DataWidth  SRAM read data
busy_o  out  1  request register or read pipeline non-empty

Behaviour:
- Reset (asynchronous, rst_i=1) sets every flop to zero:
  - sram_req_o=0, sram_we_o=0, sram_addr_o=0, sram_wdata_o=0, sram_be_o=0
  - resp_valid_o=0, busy_o=0
  - round-robin pointer = 0
  - read pipeline emptied
- req_ready_o is combinational. The granted requester is the first requester with req_valid_i set, searching from the pointer upward with wrap-around. The arbiter always grants when any request is valid; there is no SRAM-side backpressure.
- Handshake: transfer occurs when req_valid_i[i] & req_ready_o[i]. Requesters must hold valid and payload until granted. Dropping valid before grant is legal (no transaction).
- Pointer update: on a transfer from index g, pointer <= (g+1) mod NumReq. With no transfer, the pointer holds. Wrap-around: g=NumReq-1 sets the pointer to 0.
- Request register: a transfer in cycle t drives sram_req_o=1 with the granted we/addr/wdata/be in cycle t+1. With no transfer, sram_req_o=0 and the payload flops hold their value (req deasserted is sufficient).
- Read tracking: for each transfer with we=0, push {valid, one-hot id} into a Latency-stage shift register starting at cycle t+1. Writes push valid=0.
- Response: resp_valid_o[i]=1 in cycle t+1+Latency. resp_rdata_o = sram_rdata_i passes through combinationally when the tail is valid; otherwise resp_rdata_o is 0.
- There is no response backpressure; consumers must accept.
- Throughput: one request per cycle. Back-to-back reads produce back-to-back responses in issue order.
- Simultaneous write and read to the same address from different requesters: serialized by the arbiter in grant order. A read granted after the write returns the new data, because the SRAM performs the write first.
- busy_o = sram_req_o | OR of all pipeline valid bits.
- Reset mid-operation: all in-flight reads are discarded, no resp_valid_o is issued afterward, and the pointer returns to 0.

Decomposition:
- Shared package ara_pkg holds:
  - vrf_sram_req_t struct {we, addr, wdata, be}
  - resp_tag_t struct {valid, id one-hot [NumReq]}
- One sub-module: vector_d_sram_rr_arb, the combinational round-robin priority picker taking valid and pointer, producing one-hot grant and encoded index. The top holds the pointer, request register and shift register.

Test Plan:
1. Reset, then idle: assert rst_i mid-cycle -> all outputs 0 immediately; after release with no valid, busy_o=0 and sram_req_o=0.
2. Single write then read: req0 writes addr 5, data 0xDEAD..., be all-ones; next cycle req0 reads addr 5 -> sram_req_o high at t+1 and t+2; resp_valid_o=4'b0001 at t+2+Latency with the written data.
3. Fairness: all 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses arrive in the same order, one per cycle.
4. Pointer wrap and skip: pointer=3 with only req1 valid -> req1 granted; next pointer=2.
5. Latency=3 configuration: reads from req2 at cycles 0,1,2 -> resp_valid_o[2] high at cycles 4,5,6; busy_o stays high until cycle 6.
6. Reset during pending reads: issue 2 reads, assert rst_i before the first response -> no resp_valid_o ever asserted; pointer=0 after release.

Source files
------------

// File: rtl/ara_pkg.sv
// Shared types for the lane's vector data SRAM request path.
// Holds the default sizing, the SRAM request payload struct and the
// read-return tag carried through the latency pipeline.
package ara_pkg;

  localparam int unsigned AraNumReq    = 4;
  localparam int unsigned AraNumWords  = 1024;
  localparam int unsigned AraDataWidth = 128;
  localparam int unsigned AraByteWidth = 8;
  localparam int unsigned AraAddrWidth = $clog2(AraNumWords);
  localparam int unsigned AraBeWidth   = (AraDataWidth + AraByteWidth - 1) / AraByteWidth;

  // One SRAM access as registered toward the macro.
  typedef struct packed {
    logic                    we;
    logic [AraAddrWidth-1:0] addr;
    logic [AraDataWidth-1:0] wdata;
    logic [AraBeWidth-1:0]   be;
  } vrf_sram_req_t;

  // Tracks a read in flight: valid plus one-hot originating requester.
  typedef struct packed {
    logic                 valid;
    logic [AraNumReq-1:0] id;
  } resp_tag_t;

endpackage

// File: rtl/vector_d_sram_req_arbiter_if.sv
// Requester-side bus of the vector data SRAM arbiter.
// Signals keep the arbiter's point of view in their suffix:
//   req_valid_i/req_we_i/req_addr_i/req_wdata_i/req_be_i : flattened per-requester request
//   req_ready_o  : per-requester grant (one-hot or zero, combinational)
//   resp_valid_o : one-hot read-data valid
//   resp_rdata_o : read data shared by all requesters
// master = requesters, slave = arbiter.
interface vector_d_sram_req_arbiter_if
  import ara_pkg::*;
#(
  parameter int unsigned NumReq    = AraNumReq,
  parameter int unsigned AddrWidth = AraAddrWidth,
  parameter int unsigned DataWidth = AraDataWidth,
  parameter int unsigned BeWidth   = AraBeWidth
) ();

  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq-1:0]           req_we_i;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq*DataWidth-1:0] req_wdata_i;
  logic [NumReq*BeWidth-1:0]   req_be_i;
  logic [NumReq-1:0]           resp_valid_o;
  logic [DataWidth-1:0]        resp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output req_ready_o, resp_valid_o, resp_rdata_o
  );

endinterface

// File: rtl/vector_d_sram_rr_arb.sv
// Combinational round-robin picker.
// Ports: valid_i (request mask), ptr_i (highest-priority index),
//        gnt_o (one-hot grant), gnt_idx_o (encoded grant), gnt_any_o (any grant).
// The first valid requester at or above ptr_i, wrapping around, wins.
module vector_d_sram_rr_arb #(
  parameter  int unsigned NumReq   = 4,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   valid_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                gnt_any_o
);

  // Walk the candidates in priority order; the first valid one is taken.
  always_comb begin
    int unsigned cand;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(ptr_i) + k) % NumReq;
      if (!gnt_any_o && valid_i[cand]) begin
        gnt_any_o   = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/vector_d_sram_req_arbiter.sv
// Vector data SRAM request arbiter.
// Round-robin arbitrates the requesters onto one SRAM port, registers the
// winning access toward the SRAM and steers read data back to its
// originator after the SRAM latency.
// Ports: clk_i, rst_i (async, active-high);
//        req_if    : requester bus (slave side), see vector_d_sram_req_arbiter_if;
//        sram_*_o  : registered SRAM request/we/addr/wdata/be;
//        sram_rdata_i : SRAM read data;
//        busy_o    : request register or read pipeline occupied.
// Payload structs take their widths from ara_pkg, so widths must stay at
// the package defaults; Latency is freely configurable.
module vector_d_sram_req_arbiter
  import ara_pkg::*;
#(
  parameter  int unsigned NumReq    = AraNumReq,
  parameter  int unsigned NumWords  = AraNumWords,
  parameter  int unsigned DataWidth = AraDataWidth,
  parameter  int unsigned ByteWidth = AraByteWidth,
  parameter  int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  vector_d_sram_req_arbiter_if.slave req_if,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [AddrWidth-1:0]     sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [BeWidth-1:0]       sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i,
  output logic                     busy_o
);

  localparam int unsigned IdxWidth = $clog2(NumReq);

  logic [NumReq-1:0]   gnt;
  logic [IdxWidth-1:0] gnt_idx;
  logic                gnt_any;

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic                req_q, req_d;
  vrf_sram_req_t       pay_q, pay_d;
  // Stage 0 rides alongside the request register; stage Latency is the tail
  // that lines up with the SRAM read data.
  resp_tag_t           tag_q [Latency+1];
  resp_tag_t           tag_d [Latency+1];

  vector_d_sram_rr_arb #(.NumReq(NumReq)) u_rr_arb (
    .valid_i   (req_if.req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign req_if.req_ready_o = gnt;

  // Next state: pointer advance, payload capture, read-tag shift.
  always_comb begin
    ptr_d    = ptr_q;
    req_d    = gnt_any;
    pay_d    = pay_q;
    tag_d[0] = '0;
    for (int unsigned s = 1; s <= Latency; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    if (gnt_any) begin
      ptr_d       = (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + IdxWidth'(1);
      pay_d.we    = req_if.req_we_i[gnt_idx];
      pay_d.addr  = req_if.req_addr_i[gnt_idx*AddrWidth +: AddrWidth];
      pay_d.wdata = req_if.req_wdata_i[gnt_idx*DataWidth +: DataWidth];
      pay_d.be    = req_if.req_be_i[gnt_idx*BeWidth +: BeWidth];
      // Writes occupy a pipeline slot but never produce a response.
      tag_d[0].valid = ~req_if.req_we_i[gnt_idx];
      tag_d[0].id    = gnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      req_q <= 1'b0;
      pay_q <= '0;
      for (int unsigned s = 0; s <= Latency; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      req_q <= req_d;
      pay_q <= pay_d;
      tag_q <= tag_d;
    end
  end

  assign sram_req_o   = req_q;
  assign sram_we_o    = pay_q.we;
  assign sram_addr_o  = pay_q.addr;
  assign sram_wdata_o = pay_q.wdata;
  assign sram_be_o    = pay_q.be;

  // Read data is passed straight through and gated by the tail tag.
  assign req_if.resp_valid_o = tag_q[Latency].valid ? tag_q[Latency].id : '0;
  assign req_if.resp_rdata_o = tag_q[Latency].valid ? sram_rdata_i : '0;

  always_comb begin
    busy_o = req_q;
    for (int unsigned s = 0; s <= Latency; s++) begin
      busy_o = busy_o | tag_q[s].valid;
    end
  end

endmodule
